// File: rtl/vending_fsm_multi.sv
// -----------------------------------------------------------------------------
// vending_fsm_multi
//
// Purpose:
//   Multi-item vending controller. It accumulates credit from 5- and 10-unit
//   coin pulses up to a ceiling, vends one of NUM_ITEMS priced items, and
//   returns change or a cancel refund as a train of single-cycle 5-unit
//   change pulses. Every output is registered, so a response appears in the
//   cycle after the edge that sampled the request.
//
// State table:
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   S_IDLE   | waiting for coins, a selection or a cancel
//   S_VEND   | one-cycle dispense of the latched item; price taken off credit
//   S_CHANGE | one 5-unit change pulse per cycle until credit reaches 0
//
// Ports:
//   i_clk           system clock, rising-edge active
//   i_reset         synchronous active-high reset
//   i_coin_5        single-cycle pulse, 5-unit coin inserted
//   i_coin_10       single-cycle pulse, 10-unit coin inserted
//   i_select        one-hot item request, one cycle wide
//   i_cancel        single-cycle pulse, refund all credit
//   o_dispense      one-cycle pulse per vend
//   o_item_id       vended item index while o_dispense=1, else 0
//   o_change        one cycle per returned 5-unit coin
//   o_credit        current credit
//   o_busy          high whenever the FSM is not idle
//   o_reject_coin   one-cycle pulse, a coin was refused
//   o_insufficient  one-cycle pulse, selection refused for low credit
// -----------------------------------------------------------------------------
module vending_fsm_multi #(
  parameter int                             NUM_ITEMS  = 4,
  parameter int                             PRICE_W    = 8,
  parameter logic [NUM_ITEMS*PRICE_W-1:0]   PRICES     = {8'd25, 8'd20, 8'd15, 8'd10},
  parameter int                             MAX_CREDIT = 50,
  parameter int                             ID_W       = 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_coin_5,
  input  logic                 i_coin_10,
  input  logic [NUM_ITEMS-1:0] i_select,
  input  logic                 i_cancel,
  output logic                 o_dispense,
  output logic [ID_W-1:0]      o_item_id,
  output logic                 o_change,
  output logic [PRICE_W-1:0]   o_credit,
  output logic                 o_busy,
  output logic                 o_reject_coin,
  output logic                 o_insufficient
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_VEND   = 2'd1;
  localparam logic [1:0] S_CHANGE = 2'd2;

  // Coin arithmetic is done one bit wider than the credit register so the
  // ceiling check can never be fooled by a wrap.
  localparam logic [PRICE_W:0]   LP_FIVE_X  = (PRICE_W+1)'(5);
  localparam logic [PRICE_W:0]   LP_TEN_X   = (PRICE_W+1)'(10);
  localparam logic [PRICE_W:0]   LP_MAX_X   = (PRICE_W+1)'(MAX_CREDIT);
  localparam logic [PRICE_W-1:0] LP_FIVE    = PRICE_W'(5);

  logic [1:0]          r_state;
  logic [PRICE_W-1:0]  r_credit;
  logic [ID_W-1:0]     r_item;

  logic [1:0]          w_nxt_state;
  logic [PRICE_W-1:0]  w_nxt_credit;
  logic [ID_W-1:0]     w_nxt_item;
  logic                w_reject;
  logic                w_insufficient;

  logic                w_coin_any;
  logic [PRICE_W:0]    w_coin_sum;
  logic [PRICE_W:0]    w_credit_plus;
  logic                w_over_max;

  logic                w_sel_onehot;
  logic [ID_W-1:0]     w_sel_idx;
  logic [PRICE_W-1:0]  w_sel_price;
  logic [PRICE_W-1:0]  w_vend_price;
  logic [PRICE_W-1:0]  w_vend_rem;

  // ---------------------------------------------------------------------------
  // Coin sum and ceiling check
  // ---------------------------------------------------------------------------
  assign w_coin_any    = i_coin_5 | i_coin_10;
  assign w_coin_sum    = (i_coin_5  ? LP_FIVE_X : '0) +
                         (i_coin_10 ? LP_TEN_X  : '0);
  assign w_credit_plus = {1'b0, r_credit} + w_coin_sum;
  assign w_over_max    = (w_credit_plus > LP_MAX_X);

  // ---------------------------------------------------------------------------
  // Selection decode. A pattern with zero or several bits set is not a
  // request; x & (x-1) clears the lowest set bit, so it is zero only for
  // patterns with at most one bit set.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_sel_onehot = (i_select != '0) &&
                   ((i_select & (i_select - NUM_ITEMS'(1))) == '0);
    w_sel_idx = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (i_select[i]) begin
        w_sel_idx = ID_W'(i);
      end
    end
  end

  // Price lookups use constant part-selects so no index can run off the end
  // of PRICES when NUM_ITEMS is not a power of two.
  always_comb begin
    w_sel_price  = '0;
    w_vend_price = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (w_sel_idx == ID_W'(i)) begin
        w_sel_price = PRICES[i*PRICE_W +: PRICE_W];
      end
      if (r_item == ID_W'(i)) begin
        w_vend_price = PRICES[i*PRICE_W +: PRICE_W];
      end
    end
  end

  assign w_vend_rem = r_credit - w_vend_price;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_credit   = r_credit;
    w_nxt_item     = r_item;
    w_reject       = 1'b0;
    w_insufficient = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_cancel) begin
          // A coin arriving with a cancel is handed straight back.
          w_reject = w_coin_any;
          if (r_credit != '0) begin
            w_nxt_state = S_CHANGE;
          end
        end else if (w_coin_any) begin
          if (w_over_max) begin
            w_reject = 1'b1;
          end else begin
            w_nxt_credit = w_credit_plus[PRICE_W-1:0];
          end
        end else if (w_sel_onehot) begin
          if (r_credit >= w_sel_price) begin
            w_nxt_item  = w_sel_idx;
            w_nxt_state = S_VEND;
          end else begin
            w_insufficient = 1'b1;
          end
        end
      end

      S_VEND: begin
        w_reject     = w_coin_any;
        w_nxt_credit = w_vend_rem;
        w_nxt_state  = (w_vend_rem != '0) ? S_CHANGE : S_IDLE;
      end

      S_CHANGE: begin
        // The change pulse for the current credit is already on the output;
        // the last 5-unit pulse drops us back to idle with credit at zero.
        w_reject = w_coin_any;
        if (r_credit <= LP_FIVE) begin
          w_nxt_credit = '0;
          w_nxt_state  = S_IDLE;
        end else begin
          w_nxt_credit = r_credit - LP_FIVE;
        end
      end

      default: begin
        w_nxt_state  = S_IDLE;
        w_nxt_credit = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and registered outputs. Outputs are derived from the next state so
  // that they line up with the state they describe.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_credit       <= '0;
      r_item         <= '0;
      o_dispense     <= 1'b0;
      o_item_id      <= '0;
      o_change       <= 1'b0;
      o_busy         <= 1'b0;
      o_reject_coin  <= 1'b0;
      o_insufficient <= 1'b0;
    end else begin
      r_state        <= w_nxt_state;
      r_credit       <= w_nxt_credit;
      r_item         <= w_nxt_item;
      o_dispense     <= (w_nxt_state == S_VEND);
      o_item_id      <= (w_nxt_state == S_VEND) ? w_nxt_item : '0;
      o_change       <= (w_nxt_state == S_CHANGE);
      o_busy         <= (w_nxt_state != S_IDLE);
      o_reject_coin  <= w_reject;
      o_insufficient <= w_insufficient;
    end
  end

  assign o_credit = r_credit;

endmodule
